// File: rtl/sim_top_pkg.sv
// Shared constants and types for the simulation top-level: boot banner text,
// the "no UART data" marker and the UART sequencer state encoding.
package sim_top_pkg;

  localparam int                        BANNER_LEN = 6;
  localparam logic [8*BANNER_LEN-1:0]   BANNER     = "HELLO\n";
  localparam logic [7:0]                UART_EMPTY = 8'hFF;

  typedef enum logic {
    UART_BANNER = 1'b0,
    UART_POLL   = 1'b1
  } uart_state_e;

  // The string literal stores its first character in the most significant byte.
  function automatic logic [7:0] banner_char(input logic [2:0] idx);
    return BANNER[8*(BANNER_LEN-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/sim_uart_seq.sv
// UART console sequencer: emits the boot banner one character per slot, then
// polls for input each slot and echoes any character that is not UART_EMPTY.
module sim_uart_seq
  import sim_top_pkg::*;
#(
  parameter int UART_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_ch,
  output logic       out_valid,
  output logic [7:0] out_ch,
  output logic       in_valid
);

  localparam int SW = $clog2(UART_GAP);

  uart_state_e   state_q, state_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]    char_idx_q, char_idx_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_ch_q, out_ch_d;
  logic          in_valid_q, in_valid_d;
  logic          slot_fire;

  always_comb begin
    slot_fire   = (slot_cnt_q == '0);
    slot_cnt_d  = (slot_cnt_q == SW'(UART_GAP-1)) ? '0 : slot_cnt_q + 1'b1;
    state_d     = state_q;
    char_idx_d  = char_idx_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    in_valid_d  = 1'b0;
    case (state_q)
      UART_BANNER: begin
        if (slot_fire) begin
          out_valid_d = 1'b1;
          out_ch_d    = banner_char(char_idx_q);
          char_idx_d  = char_idx_q + 3'd1;
          if (char_idx_q == 3'(BANNER_LEN-1)) begin
            state_d = UART_POLL;
          end
        end
      end
      UART_POLL: begin
        if (slot_fire) begin
          in_valid_d = 1'b1;
        end
        // The poll cycle ends on the edge where the request strobe is still high.
        if (in_valid_q && (in_ch != UART_EMPTY)) begin
          out_valid_d = 1'b1;
          out_ch_d    = in_ch;
        end
      end
      default: state_d = UART_BANNER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= UART_BANNER;
      slot_cnt_q  <= '0;
      char_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      in_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      char_idx_q  <= char_idx_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      in_valid_q  <= in_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign in_valid  = in_valid_q;

endmodule

// File: rtl/sim_top.sv
// Simulation stand-in for the SoC: cycle counter, difftest commit ticker, perf
// counters and UART console. Define SIMTOP_LOG_EN to enable windowed logging.
module sim_top
  import sim_top_pkg::*;
#(
  parameter int COMMIT_INTERVAL = 4,
  parameter int UART_GAP        = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] io_logCtrl_log_begin,
  input  logic [63:0] io_logCtrl_log_end,
  input  logic [63:0] io_logCtrl_log_level,
  input  logic        io_perfInfo_clean,
  input  logic        io_perfInfo_dump,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch,
  output logic        difftest_step
);

  localparam int DW = $clog2(COMMIT_INTERVAL);

  logic [63:0]   cycle_cnt_q, cycle_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          step_q, step_d;
  logic [31:0]   commit_cnt_q, commit_cnt_d;
  logic [31:0]   uart_tx_cnt_q, uart_tx_cnt_d;
  logic          div_wrap;

  sim_uart_seq #(.UART_GAP(UART_GAP)) u_uart (
    .clk       (clock),
    .rst_n     (reset),
    .in_ch     (io_uart_in_ch),
    .out_valid (io_uart_out_valid),
    .out_ch    (io_uart_out_ch),
    .in_valid  (io_uart_in_valid)
  );

  always_comb begin
    div_wrap      = (div_cnt_q == DW'(COMMIT_INTERVAL-1));
    cycle_cnt_d   = cycle_cnt_q + 64'd1;
    div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
    step_d        = div_wrap;
    commit_cnt_d  = commit_cnt_q + {31'd0, div_wrap};
    uart_tx_cnt_d = uart_tx_cnt_q + {31'd0, io_uart_out_valid};
    // Clean wins over any increment landing on the same edge.
    if (io_perfInfo_clean) begin
      commit_cnt_d  = '0;
      uart_tx_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      div_cnt_q     <= '0;
      step_q        <= 1'b0;
      commit_cnt_q  <= '0;
      uart_tx_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      div_cnt_q     <= div_cnt_d;
      step_q        <= step_d;
      commit_cnt_q  <= commit_cnt_d;
      uart_tx_cnt_q <= uart_tx_cnt_d;
    end
  end

  assign difftest_step = step_q;

`ifndef SYNTHESIS
  // Registered values are pre-edge, so a same-edge clean still dumps old counts.
  always_ff @(posedge clock) begin
    if (reset && io_perfInfo_dump) begin
      $display("[perf] cycle=%0d commit_cnt=%0d uart_tx_cnt=%0d",
               cycle_cnt_q, commit_cnt_q, uart_tx_cnt_q);
    end
  end
`endif

`ifdef SIMTOP_LOG_EN
  logic log_active;
  assign log_active = (cycle_cnt_q >= io_logCtrl_log_begin) &&
                      (cycle_cnt_q <  io_logCtrl_log_end);

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset && log_active) begin
      if (step_q) begin
        $display("commit %0d @ %0d", commit_cnt_q, cycle_cnt_q);
      end
      if (io_uart_out_valid && (io_logCtrl_log_level >= 64'd1)) begin
        $display("uart 0x%02h @ %0d", io_uart_out_ch, cycle_cnt_q);
      end
    end
  end
`endif
`else
  logic unused_log;
  assign unused_log = ^{io_logCtrl_log_begin, io_logCtrl_log_end, io_logCtrl_log_level};
`endif

endmodule

// File: tb/tb_sim_top.sv
// Directed bench for sim_top with default parameters: reset, banner, poll/echo,
// commit cadence, perf clean and mid-run reset.
module tb_sim_top;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] log_begin, log_end, log_level;
  logic        perf_clean, perf_dump;
  logic        uart_out_valid;
  logic [7:0]  uart_out_ch;
  logic        uart_in_valid;
  logic [7:0]  uart_in_ch;
  logic        step;

  int n_tests = 0;
  int n_fail  = 0;
  bit echo_en = 1'b0;

  logic [7:0] ban [6];

  always #5 clock = ~clock;

  sim_top dut (
    .clock                (clock),
    .reset                (reset),
    .io_logCtrl_log_begin (log_begin),
    .io_logCtrl_log_end   (log_end),
    .io_logCtrl_log_level (log_level),
    .io_perfInfo_clean    (perf_clean),
    .io_perfInfo_dump     (perf_dump),
    .io_uart_out_valid    (uart_out_valid),
    .io_uart_out_ch       (uart_out_ch),
    .io_uart_in_valid     (uart_in_valid),
    .io_uart_in_ch        (uart_in_ch),
    .difftest_step        (step)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check all outputs after non-reset edge n against the default schedule.
  task automatic edge_check(input int n);
    logic       exp_ov;
    logic [7:0] exp_ch;
    tick();
    exp_ov = ((n % 2 == 1) && (n <= 11)) || ((n == 14) && echo_en);
    exp_ch = (n == 14) ? 8'h41 : ban[((n - 1) / 2) % 6];
    check($sformatf("e%0d step", n), {63'd0, step}, {63'd0, (n % 4 == 0)});
    check($sformatf("e%0d out_valid", n), {63'd0, uart_out_valid}, {63'd0, exp_ov});
    if (exp_ov) check($sformatf("e%0d out_ch", n), {56'd0, uart_out_ch}, {56'd0, exp_ch});
    check($sformatf("e%0d in_valid", n), {63'd0, uart_in_valid},
          {63'd0, (n >= 13) && (n % 2 == 1)});
    check($sformatf("e%0d cycle_cnt", n), dut.cycle_cnt_q, 64'(n));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " outputs"}, {53'd0, uart_out_valid, uart_out_ch, uart_in_valid, step}, 64'd0);
    check({tag, " cycle_cnt"}, dut.cycle_cnt_q, 64'd0);
  endtask

  initial begin
    ban[0] = "H"; ban[1] = "E"; ban[2] = "L"; ban[3] = "L"; ban[4] = "O"; ban[5] = 8'h0A;
    reset      = 1'b0;
    log_begin  = 64'd5;
    log_end    = 64'd9;
    log_level  = 64'd1;
    perf_clean = 1'b0;
    perf_dump  = 1'b0;
    uart_in_ch = 8'hFF;

    // Reset held for 5 edges.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_zero($sformatf("rst%0d", i));
    end
    reset = 1'b1;

    // Banner, polls, echo, commits and perf clean.
    echo_en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      edge_check(n);
      if (n == 12) begin
        check("commit_cnt@12", 64'(dut.commit_cnt_q), 64'd3);
        check("uart_tx_cnt@12", 64'(dut.uart_tx_cnt_q), 64'd6);
      end
      if (n == 13) begin
        check("commit_cnt clean", 64'(dut.commit_cnt_q), 64'd0);
        check("uart_tx_cnt clean", 64'(dut.uart_tx_cnt_q), 64'd0);
      end
      if (n == 20) begin
        check("commit_cnt@20", 64'(dut.commit_cnt_q), 64'd2);
        check("uart_tx_cnt@20", 64'(dut.uart_tx_cnt_q), 64'd1);
      end
      uart_in_ch = (n == 13) ? 8'h41 : 8'hFF;
      perf_clean = (n == 12);
      perf_dump  = (n == 12) || (n == 19);
    end
    perf_dump = 1'b0;
    echo_en   = 1'b0;

    // Fresh start, then reset dropped after edge 6.
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int n = 1; n <= 6; n++) edge_check(n);
    reset = 1'b0;
    tick();
    check_zero("midrst");
    check("midrst commit_cnt", 64'(dut.commit_cnt_q), 64'd0);
    tick();
    reset = 1'b1;
    for (int n = 1; n <= 5; n++) edge_check(n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
